// File: rtl/ghost_mode_if.sv
// ghost_mode_if: frame strobe, game events and AI outputs exchanged between the
// game logic (master) and the per-ghost mode controller (slave).
interface ghost_mode_if;
    logic       ce;
    logic       level_start;
    logic       power_pellet;
    logic       ghost_eaten;
    logic       at_home;
    logic [3:0] aiState;
    logic [5:0] aiTimer;
    logic       reverse;

    modport master (
        output ce, level_start, power_pellet, ghost_eaten, at_home,
        input  aiState, aiTimer, reverse
    );

    modport slave (
        input  ce, level_start, power_pellet, ghost_eaten, at_home,
        output aiState, aiTimer, reverse
    );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: per-ghost behaviour-mode controller. Runs the scatter/chase
// phase schedule, frightened countdown, dead-return and house dwell, all paced
// by the frame strobe, and emits a one-cycle direction-reversal pulse.
// Optional feature macro: GHOST_FRIGHT_RELOAD_EN (an energizer eaten while
// frightened reloads the countdown instead of being ignored).
module ghost_mode_ctrl #(
    parameter int SCATTER_LONG       = 420,
    parameter int SCATTER_SHORT      = 300,
    parameter int CHASE_LEN          = 1200,
    parameter int FRIGHT_TICKS       = 48,
    parameter int FRIGHT_TICK_FRAMES = 8,
    parameter int HOUSE_FRAMES       = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    ghost_mode_if.slave bus
);

    typedef enum logic [3:0] {
        ST_SCATTER    = 4'd0,
        ST_CHASE      = 4'd1,
        ST_FRIGHTENED = 4'd2,
        ST_HOUSE      = 4'd3,
        ST_DEAD       = 4'd4
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  timer_q, timer_d;
    logic        rev_q, rev_d;
    logic [2:0]  ph_q, ph_d;
    logic [11:0] phase_cnt_q, phase_cnt_d;
    logic [7:0]  sub_q, sub_d;
    logic [11:0] house_q, house_d;
    state_e      base_s;
    state_e      next_base_s;
    logic        reload_s;

    // Last frame index (length minus one) of each schedule phase.
    function automatic logic [11:0] phase_last(input logic [2:0] p);
        case (p)
            3'd0, 3'd2: phase_last = 12'(SCATTER_LONG - 1);
            3'd4, 3'd6: phase_last = 12'(SCATTER_SHORT - 1);
            default:    phase_last = 12'(CHASE_LEN - 1);
        endcase
    endfunction

    // Scheduled mode of a phase: even phases below 7 scatter, the rest chase.
    function automatic state_e base_of(input logic [2:0] p);
        if ((p[0] == 1'b0) && (p != 3'd7)) begin
            base_of = ST_SCATTER;
        end else begin
            base_of = ST_CHASE;
        end
    endfunction

    // Next-state logic; events are tested in priority order so a pellet or
    // arrival event consumes the cycle and any coincident frame count is lost.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rev_d       = 1'b0;
        ph_d        = ph_q;
        phase_cnt_d = phase_cnt_q;
        sub_d       = sub_q;
        house_d     = house_q;
        base_s      = base_of(ph_q);
        next_base_s = base_of(ph_q + 3'd1);
`ifdef GHOST_FRIGHT_RELOAD_EN
        reload_s    = bus.power_pellet;
`else
        reload_s    = 1'b0;
`endif

        if (bus.level_start) begin
            state_d     = ST_SCATTER;
            timer_d     = 6'd0;
            ph_d        = 3'd0;
            phase_cnt_d = 12'd0;
            sub_d       = 8'd0;
            house_d     = 12'd0;
        end else begin
            case (state_q)
                ST_SCATTER, ST_CHASE: begin
                    if (bus.power_pellet) begin
                        state_d = ST_FRIGHTENED;
                        timer_d = 6'(FRIGHT_TICKS);
                        sub_d   = 8'd0;
                        rev_d   = 1'b1;
                    end else if (bus.ce) begin
                        if (phase_cnt_q == phase_last(ph_q)) begin
                            if (ph_q != 3'd7) begin
                                ph_d        = ph_q + 3'd1;
                                phase_cnt_d = 12'd0;
                                state_d     = next_base_s;
                                rev_d       = (next_base_s != base_s);
                            end else begin
                                phase_cnt_d = phase_cnt_q;   // final chase never ends
                            end
                        end else begin
                            phase_cnt_d = phase_cnt_q + 12'd1;
                        end
                    end else begin
                        phase_cnt_d = phase_cnt_q;
                    end
                end
                ST_FRIGHTENED: begin
                    if (bus.ghost_eaten) begin
                        state_d = ST_DEAD;
                        timer_d = 6'd0;
                    end else if (reload_s) begin
                        timer_d = 6'(FRIGHT_TICKS);
                        sub_d   = 8'd0;
                    end else if (bus.ce) begin
                        if (sub_q == 8'(FRIGHT_TICK_FRAMES - 1)) begin
                            sub_d = 8'd0;
                            if (timer_q <= 6'd1) begin
                                state_d = base_s;
                                timer_d = 6'd0;
                            end else begin
                                timer_d = timer_q - 6'd1;
                            end
                        end else begin
                            sub_d = sub_q + 8'd1;
                        end
                    end else begin
                        sub_d = sub_q;
                    end
                end
                ST_DEAD: begin
                    if (bus.at_home) begin
                        state_d = ST_HOUSE;
                        house_d = 12'd0;
                    end else begin
                        state_d = ST_DEAD;
                    end
                end
                ST_HOUSE: begin
                    if (bus.ce) begin
                        if (house_q == 12'(HOUSE_FRAMES - 1)) begin
                            state_d = base_s;
                            house_d = 12'd0;
                        end else begin
                            house_d = house_q + 12'd1;
                        end
                    end else begin
                        house_d = house_q;
                    end
                end
                default: begin
                    state_d     = ST_SCATTER;
                    timer_d     = 6'd0;
                    ph_d        = 3'd0;
                    phase_cnt_d = 12'd0;
                    sub_d       = 8'd0;
                    house_d     = 12'd0;
                end
            endcase
        end
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCATTER;
            timer_q     <= 6'd0;
            rev_q       <= 1'b0;
            ph_q        <= 3'd0;
            phase_cnt_q <= 12'd0;
            sub_q       <= 8'd0;
            house_q     <= 12'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rev_q       <= rev_d;
            ph_q        <= ph_d;
            phase_cnt_q <= phase_cnt_d;
            sub_q       <= sub_d;
            house_q     <= house_d;
        end
    end

    assign bus.aiState = state_q;
    assign bus.aiTimer = timer_q;
    assign bus.reverse = rev_q;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// tb_ghost_mode_ctrl: vector table, directed corner sequences and a random run
// checked against a frames-remaining reference model of the ghost schedule.
module tb_ghost_mode_ctrl;
    localparam int FT  = 48;
    localparam int FTF = 8;
    localparam int HF  = 60;
`ifdef GHOST_FRIGHT_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ghost_mode_if bus();
    ghost_mode_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit ls; bit pp; bit ge; bit ah; bit ce;
        int st; int tm; int rv;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int rev_seen = 0;

    // reference model: remaining-frame budgets per activity
    int m_state, m_timer, m_rev, m_ph, m_left, m_fleft, m_hleft;

    function automatic int plen(input int p);
        if (p == 0 || p == 2) return 420;
        if (p == 4 || p == 6) return 300;
        return 1200;
    endfunction

    function automatic int base_m(input int p);
        return ((p % 2 == 0) && (p < 7)) ? 0 : 1;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_timer = 0; m_rev = 0; m_ph = 0;
        m_left = plen(0); m_fleft = 0; m_hleft = 0;
    endfunction

    function automatic void model_step(input bit ls, pp, ge, ah, c);
        int nb;
        m_rev = 0;
        if (ls) begin
            model_reset();
        end else if (ge && m_state == 2) begin
            m_state = 4; m_timer = 0;
        end else if (pp && m_state <= 1) begin
            m_state = 2; m_fleft = FT * FTF; m_timer = FT; m_rev = 1;
        end else if (pp && m_state == 2 && RELOAD) begin
            m_fleft = FT * FTF; m_timer = FT;
        end else if (ah && m_state == 4) begin
            m_state = 3; m_hleft = HF;
        end else if (c) begin
            if (m_state <= 1) begin
                if (m_ph < 7) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ph++;
                        m_left = plen(m_ph);
                        nb = base_m(m_ph);
                        m_rev = (nb != m_state) ? 1 : 0;
                        m_state = nb;
                    end
                end
            end else if (m_state == 2) begin
                m_fleft--;
                m_timer = (m_fleft + FTF - 1) / FTF;
                if (m_fleft == 0) m_state = base_m(m_ph);
            end else if (m_state == 3) begin
                m_hleft--;
                if (m_hleft == 0) m_state = base_m(m_ph);
            end
        end
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // drive one cycle at the falling edge, sample at the next falling edge
    task automatic step(input bit ls, pp, ge, ah, c);
        bus.level_start  = ls;
        bus.power_pellet = pp;
        bus.ghost_eaten  = ge;
        bus.at_home      = ah;
        bus.ce           = c;
        model_step(ls, pp, ge, ah, c);
        @(negedge clk);
        if (bus.reverse) rev_seen++;
        check("model_state", int'(bus.aiState), m_state);
        check("model_timer", int'(bus.aiTimer), m_timer);
        check("model_reverse", int'(bus.reverse), m_rev);
    endtask

    task automatic idle_ce(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic expect_out(input string nm, input int st, input int tm, input int rv);
        check({nm, "_state"}, int'(bus.aiState), st);
        check({nm, "_timer"}, int'(bus.aiTimer), tm);
        check({nm, "_reverse"}, int'(bus.reverse), rv);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1,0,0,0,0, 0, 0,0};
        vecs[1]  = '{0,0,0,0,1, 0, 0,0};
        vecs[2]  = '{0,0,1,0,0, 0, 0,0};
        vecs[3]  = '{0,0,0,1,0, 0, 0,0};
        vecs[4]  = '{0,1,0,0,0, 2,48,1};
        vecs[5]  = '{0,0,0,0,0, 2,48,0};
        vecs[6]  = '{0,1,0,0,0, 2,48,0};
        vecs[7]  = '{0,1,1,0,0, 4, 0,0};
        vecs[8]  = '{0,1,0,0,0, 4, 0,0};
        vecs[9]  = '{0,0,0,0,1, 4, 0,0};
        vecs[10] = '{0,0,0,1,1, 3, 0,0};
        vecs[11] = '{0,1,0,0,0, 3, 0,0};
        vecs[12] = '{0,0,1,0,0, 3, 0,0};
        vecs[13] = '{1,0,1,0,0, 0, 0,0};
        vecs[14] = '{0,1,0,0,1, 2,48,1};
        vecs[15] = '{1,1,0,0,0, 0, 0,0};

        bus.level_start = 1'b0; bus.power_pellet = 1'b0; bus.ghost_eaten = 1'b0;
        bus.at_home = 1'b0; bus.ce = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0);
        rst_n = 1'b1;

        // vector table
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].ls, vecs[i].pp, vecs[i].ge, vecs[i].ah, vecs[i].ce);
            expect_out("vec", vecs[i].st, vecs[i].tm, vecs[i].rv);
        end

        // first scatter ends on strobe 420
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rev_seen = 0;
        idle_ce(419);
        expect_out("scatter419", 0, 0, 0);
        idle_ce(1);
        expect_out("scatter420", 1, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("after420", 1, 0, 0);
        check("rev_count_first", rev_seen, 1);

        // whole schedule, then chase forever
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rev_seen = 0;
        idle_ce((7 + 20 + 7 + 20 + 5 + 20 + 5) * 60 + 600);
        check("sched_final_state", int'(bus.aiState), 1);
        check("sched_rev_count", rev_seen, 7);

        // energizer at frame 100 of scatter freezes the schedule
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_ce(100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("fright_entry", 2, 48, 1);
        idle_ce(383);
        expect_out("fright_last", 2, 1, 0);
        idle_ce(1);
        expect_out("fright_exit", 0, 0, 0);
        idle_ce(319);
        expect_out("resume319", 0, 0, 0);
        idle_ce(1);
        expect_out("resume320", 1, 0, 1);

        // eaten, return home, dwell
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("dead", 4, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("house", 3, 0, 0);
        idle_ce(59);
        expect_out("house59", 3, 0, 0);
        idle_ce(1);
        expect_out("house_exit", 0, 0, 0);

        // energizer with five ticks left
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_ce(43 * 8);
        expect_out("timer5", 2, 5, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pellet_at5", int'(bus.aiTimer), RELOAD ? 48 : 5);
        check("pellet_at5_rev", int'(bus.reverse), 0);

        // asynchronous reset while dead with all events asserted
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("pre_rst_dead", 4, 0, 0);
        bus.ghost_eaten = 1'b1; bus.power_pellet = 1'b1; bus.ce = 1'b1;
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0);
        model_reset();
        @(negedge clk);
        expect_out("rst_hold", 0, 0, 0);
        bus.ghost_eaten = 1'b0; bus.power_pellet = 1'b0; bus.ce = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("post_rst", 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 15000; i++) begin
            step($urandom_range(0, 1999) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
